// File: rtl/bridge_gate_driver.sv
// Full-bridge gate driver: per-leg dead-time FSMs, sticky shoot-through fault,
// sigma reconstruction from applied gates, half-period and switch-count measurement.
module bridge_gate_driver #(
  parameter int DEADTIME = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                i_clock,
  input  logic                i_RESET,
  input  logic [3:0]          i_MOSFET,
  input  logic                i_enable,
  input  logic                i_clear_fault,
  output logic [3:0]          o_gate,
  output logic [1:0]          o_sigma,
  output logic                o_fault,
  output logic [PERIOD_W-1:0] o_half_period,
  output logic                o_period_valid,
  output logic [PERIOD_W-1:0] o_switch_count
);

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_HIGH = 2'd1,
    LEG_LOW  = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_t;

  // Handshake: none; i_MOSFET is a level command sampled every cycle into cmd_q.
  logic [3:0]    cmd_q;
  logic          fault_q;
  logic          fault_det;
  logic          force_off;
  leg_state_t    state_q [2];
  leg_state_t    state_d [2];
  logic [7:0]    cnt_q   [2];
  logic [7:0]    cnt_d   [2];
  logic          tgt_q   [2];
  logic          tgt_d   [2];

  logic [1:0]          sigma_d;
  logic                sigma_chg;
  logic [PERIOD_W-1:0] cyc_q;
  logic                ref_valid_q;

  assign fault_det = (cmd_q[0] & cmd_q[2]) | (cmd_q[1] & cmd_q[3]);
  assign force_off = fault_q | fault_det | ~i_enable;

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      cmd_q   <= 4'b0000;
      fault_q <= 1'b0;
    end else begin
      cmd_q <= i_MOSFET;
      if (fault_det)
        fault_q <= 1'b1;
      else if (i_clear_fault)
        fault_q <= 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= LEG_OFF;
        cnt_q[i]   <= 8'd0;
        tgt_q[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        tgt_q[i]   <= tgt_d[i];
      end
    end
  end

  // tgt = 1 means the leg is heading for its high-side switch.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt_d[i]   = tgt_q[i];
      if (force_off) begin
        state_d[i] = LEG_OFF;
        cnt_d[i]   = 8'd0;
      end else begin
        case (state_q[i])
          LEG_OFF: begin
            if (cmd_q[i] ^ cmd_q[i+2]) begin
              state_d[i] = LEG_DEAD;
              tgt_d[i]   = cmd_q[i];
              cnt_d[i]   = 8'(DEADTIME);
            end
          end
          LEG_HIGH: begin
            if (!cmd_q[i] && !cmd_q[i+2]) begin
              state_d[i] = LEG_OFF;
            end else if (!cmd_q[i] && cmd_q[i+2]) begin
              state_d[i] = LEG_DEAD;
              tgt_d[i]   = 1'b0;
              cnt_d[i]   = 8'(DEADTIME);
            end
          end
          LEG_LOW: begin
            if (!cmd_q[i] && !cmd_q[i+2]) begin
              state_d[i] = LEG_OFF;
            end else if (cmd_q[i] && !cmd_q[i+2]) begin
              state_d[i] = LEG_DEAD;
              tgt_d[i]   = 1'b1;
              cnt_d[i]   = 8'(DEADTIME);
            end
          end
          LEG_DEAD: begin
            if (!cmd_q[i] && !cmd_q[i+2]) begin
              state_d[i] = LEG_OFF;
              cnt_d[i]   = 8'd0;
            end else if (cmd_q[i] != tgt_q[i]) begin
              tgt_d[i] = cmd_q[i];
              cnt_d[i] = 8'(DEADTIME);
            end else if (cnt_q[i] <= 8'd1) begin
              state_d[i] = tgt_q[i] ? LEG_HIGH : LEG_LOW;
              cnt_d[i]   = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: state_d[i] = LEG_OFF;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      o_gate[i]   = (state_q[i] == LEG_HIGH);
      o_gate[i+2] = (state_q[i] == LEG_LOW);
    end
  end

  always_comb begin
    sigma_d = o_sigma;
    case (o_gate)
      4'b1001:         sigma_d = 2'b01;
      4'b0110:         sigma_d = 2'b11;
      4'b0011, 4'b1100: sigma_d = 2'b00;
      default:         sigma_d = o_sigma;
    endcase
  end

  assign sigma_chg = i_enable && (sigma_d != o_sigma);

  // The reference is dropped last so disable/fault always wins over a same-cycle change.
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) begin
      o_sigma        <= 2'b00;
      o_half_period  <= '0;
      o_period_valid <= 1'b0;
      o_switch_count <= '0;
      cyc_q          <= '0;
      ref_valid_q    <= 1'b0;
    end else begin
      o_period_valid <= 1'b0;
      if (sigma_chg) begin
        o_sigma        <= sigma_d;
        o_half_period  <= cyc_q;
        cyc_q          <= PERIOD_W'(1);
        o_switch_count <= o_switch_count + 1'b1;
        o_period_valid <= ref_valid_q;
        ref_valid_q    <= 1'b1;
      end else if (i_enable && (cyc_q != {PERIOD_W{1'b1}})) begin
        cyc_q <= cyc_q + 1'b1;
      end
      if (!i_enable || fault_q)
        ref_valid_q <= 1'b0;
    end
  end

  assign o_fault = fault_q;

endmodule
